darkbus_arbiter: RTL and testbench



---
 rtl/darkbus_arbiter_if.sv | 53 +++++
 rtl/darkbus_arbiter.sv | 112 +++++++++++
 tb/tb_darkbus_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/darkbus_arbiter_if.sv
// Bus bundle for the darkbus arbiter: core data port, auxiliary requester and shared memory port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface darkbus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          C_DAS;
  logic          C_DRD;
  logic          C_DWR;
  logic [AW-1:0] C_DADDR;
  logic [DW-1:0] C_DATAO;
  logic [2:0]    C_DLEN;
  logic [DW-1:0] C_DATAI;
  logic          C_HLT;

  logic          A_REQ;
  logic          A_WR;
  logic [AW-1:0] A_ADDR;
  logic [DW-1:0] A_WDATA;
  logic [2:0]    A_LEN;
  logic          A_ACK;
  logic [DW-1:0] A_RDATA;

  logic          M_REQ;
  logic          M_WR;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_WDATA;
  logic [2:0]    M_LEN;
  logic          M_RDY;
  logic [DW-1:0] M_RDATA;

  logic          TOUT;

  modport slave (
    input  C_DAS, C_DRD, C_DWR, C_DADDR, C_DATAO, C_DLEN,
    output C_DATAI, C_HLT,
    input  A_REQ, A_WR, A_ADDR, A_WDATA, A_LEN,
    output A_ACK, A_RDATA,
    output M_REQ, M_WR, M_ADDR, M_WDATA, M_LEN,
    input  M_RDY, M_RDATA,
    output TOUT
  );

  modport master (
    output C_DAS, C_DRD, C_DWR, C_DADDR, C_DATAO, C_DLEN,
    input  C_DATAI, C_HLT,
    output A_REQ, A_WR, A_ADDR, A_WDATA, A_LEN,
    input  A_ACK, A_RDATA,
    input  M_REQ, M_WR, M_ADDR, M_WDATA, M_LEN,
    output M_RDY, M_RDATA,
    input  TOUT
  );
endinterface

// File: rtl/darkbus_arbiter.sv
// Round-robin arbiter sharing one memory port between the darkriscv data bus and an aux master,
// with core halt generation, registered memory handshake and a sticky watchdog timeout.
module darkbus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int WAIT_MAX = 15
) (
  input logic             CLK,
  input logic             RES,
  darkbus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, BUSY_C, BUSY_A, DONE_C, DONE_A} state_t;

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          last_a;
  logic          creq;
  logic          grant_c, grant_a;
  logic          rdy_hit, abort;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [DW-1:0] rd_val;
  logic [2:0]    sel_len;

  assign creq = bus.C_DAS & (bus.C_DRD | bus.C_DWR);

  always_ff @(posedge CLK) begin
    if (!RES) state <= IDLE;
    else      state <= next_state;
  end

  // On a tie the master that was not served last wins; last_a resets to 1 so the core goes first.
  always_comb begin
    next_state = state;
    grant_c    = 1'b0;
    grant_a    = 1'b0;
    rdy_hit    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (creq && bus.A_REQ) begin
          grant_c = last_a;
          grant_a = ~last_a;
        end else begin
          grant_c = creq;
          grant_a = bus.A_REQ;
        end
        if (grant_c)      next_state = BUSY_C;
        else if (grant_a) next_state = BUSY_A;
      end
      BUSY_C, BUSY_A: begin
        if (bus.M_RDY)            rdy_hit = 1'b1;
        else if (cnt == CNT_LAST) abort   = 1'b1;
        if (rdy_hit || abort) next_state = (state == BUSY_C) ? DONE_C : DONE_A;
      end
      DONE_C, DONE_A: next_state = IDLE;
      default:        next_state = IDLE;
    endcase
  end

  always_comb begin
    sel_wr    = grant_a ? bus.A_WR    : bus.C_DWR;
    sel_addr  = grant_a ? bus.A_ADDR  : bus.C_DADDR;
    sel_wdata = grant_a ? bus.A_WDATA : bus.C_DATAO;
    sel_len   = grant_a ? bus.A_LEN   : bus.C_DLEN;
    rd_val    = rdy_hit ? bus.M_RDATA : {DW{1'b1}};
  end

  // Memory request fields are latched at grant and held for the whole BUSY phase.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      bus.M_WR    <= 1'b0;
      bus.M_ADDR  <= '0;
      bus.M_WDATA <= '0;
      bus.M_LEN   <= '0;
      bus.C_DATAI <= '0;
      bus.A_RDATA <= '0;
      bus.TOUT    <= 1'b0;
      last_a      <= 1'b1;
      cnt         <= '0;
    end else begin
      if (grant_c || grant_a) begin
        bus.M_WR    <= sel_wr;
        bus.M_ADDR  <= sel_addr;
        bus.M_WDATA <= sel_wdata;
        bus.M_LEN   <= sel_len;
        last_a      <= grant_a;
        cnt         <= '0;
      end else if ((state == BUSY_C || state == BUSY_A) && !rdy_hit && !abort) begin
        cnt <= cnt + CW'(1);
      end
      if ((rdy_hit || abort) && !bus.M_WR) begin
        if (state == BUSY_C) bus.C_DATAI <= rd_val;
        else                 bus.A_RDATA <= rd_val;
      end
      if (abort) bus.TOUT <= 1'b1;
    end
  end

  // The core is released exactly in its DONE_C cycle.
  always_comb begin
    bus.M_REQ = (state == BUSY_C) || (state == BUSY_A);
    bus.C_HLT = creq && (state != DONE_C);
    bus.A_ACK = (state == DONE_A);
  end

endmodule

// File: tb/tb_darkbus_arbiter.sv
// Directed testbench for darkbus_arbiter: single accesses, wait states, round-robin ties,
// watchdog timeout and reset during a transfer, with hand-computed expectations.
module tb_darkbus_arbiter;

  logic clk;
  logic res;
  int   checks;
  int   errors;

  darkbus_arbiter_if #(.AW(32), .DW(32)) bus ();

  darkbus_arbiter #(.AW(32), .DW(32), .WAIT_MAX(15)) dut (
    .CLK (clk),
    .RES (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cdas, input logic crd, input logic cwr, input logic [31:0] caddr,
                               input logic [31:0] cwdata, input logic areq, input logic awr,
                               input logic [31:0] aaddr, input logic [31:0] awdata);
    bus.C_DAS   = cdas;
    bus.C_DRD   = crd;
    bus.C_DWR   = cwr;
    bus.C_DADDR = caddr;
    bus.C_DATAO = cwdata;
    bus.A_REQ   = areq;
    bus.A_WR    = awr;
    bus.A_ADDR  = aaddr;
    bus.A_WDATA = awdata;
  endtask

  // Advance to just after the next rising edge so outputs are stable when sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mreq_cycles;
    checks = 0;
    errors = 0;
    res = 1'b0;
    bus.C_DLEN  = 3'd4;
    bus.A_LEN   = 3'd4;
    bus.M_RDY   = 1'b0;
    bus.M_RDATA = 32'h0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("rst_mreq",  {31'b0, bus.M_REQ}, 32'd0);
    checkOutput("rst_tout",  {31'b0, bus.TOUT},  32'd0);
    checkOutput("rst_cdata", bus.C_DATAI,        32'h0);
    checkOutput("rst_maddr", bus.M_ADDR,         32'h0);
    checkOutput("rst_hlt",   {31'b0, bus.C_HLT}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    res = 1'b1;
    tick();

    $display("[TB] core read, zero wait");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("cr_t_hlt",  {31'b0, bus.C_HLT}, 32'd1);
    checkOutput("cr_t_mreq", {31'b0, bus.M_REQ}, 32'd0);
    tick();
    checkOutput("cr_t1_mreq",  {31'b0, bus.M_REQ}, 32'd1);
    checkOutput("cr_t1_maddr", bus.M_ADDR,         32'h100);
    checkOutput("cr_t1_mwr",   {31'b0, bus.M_WR},  32'd0);
    checkOutput("cr_t1_hlt",   {31'b0, bus.C_HLT}, 32'd1);
    bus.M_RDY   = 1'b1;
    bus.M_RDATA = 32'h12345678;
    tick();
    checkOutput("cr_t2_hlt",   {31'b0, bus.C_HLT}, 32'd0);
    checkOutput("cr_t2_cdata", bus.C_DATAI,        32'h12345678);
    checkOutput("cr_t2_mreq",  {31'b0, bus.M_REQ}, 32'd0);
    bus.M_RDY = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("[TB] aux write, two waits");
    bus.A_LEN = 3'd2;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hCAFEF00D);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput($sformatf("aw_t%0d_mreq", i), {31'b0, bus.M_REQ}, 32'd1);
      checkOutput($sformatf("aw_t%0d_mwr", i),  {31'b0, bus.M_WR},  32'd1);
      checkOutput($sformatf("aw_t%0d_wdat", i), bus.M_WDATA,        32'hCAFEF00D);
      checkOutput($sformatf("aw_t%0d_ack", i),  {31'b0, bus.A_ACK}, 32'd0);
      if (i == 3) bus.M_RDY = 1'b1;
    end
    checkOutput("aw_maddr", bus.M_ADDR,         32'h200);
    checkOutput("aw_mlen",  {29'b0, bus.M_LEN}, 32'd2);
    tick();
    checkOutput("aw_t4_ack",   {31'b0, bus.A_ACK}, 32'd1);
    checkOutput("aw_t4_rdata", bus.A_RDATA,        32'h0);
    checkOutput("aw_t4_mreq",  {31'b0, bus.M_REQ}, 32'd0);
    bus.M_RDY = 1'b0;
    bus.A_LEN = 3'd4;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("aw_t5_ack", {31'b0, bus.A_ACK}, 32'd0);

    $display("[TB] simultaneous requests after reset");
    res = 1'b0;
    tick();
    res = 1'b1;
    bus.M_RDY = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0);
    for (int g = 0; g < 4; g++) begin
      bus.M_RDATA = 32'hA0 + g;
      tick();
      checkOutput($sformatf("rr%0d_maddr", g), bus.M_ADDR,         (g % 2 == 0) ? 32'h300 : 32'h400);
      checkOutput($sformatf("rr%0d_mreq", g),  {31'b0, bus.M_REQ}, 32'd1);
      tick();
      checkOutput($sformatf("rr%0d_hlt", g),   {31'b0, bus.C_HLT}, (g % 2 == 0) ? 32'd0 : 32'd1);
      checkOutput($sformatf("rr%0d_ack", g),   {31'b0, bus.A_ACK}, (g % 2 == 0) ? 32'd0 : 32'd1);
      if (g % 2 == 0) checkOutput($sformatf("rr%0d_cdata", g), bus.C_DATAI, 32'hA0 + g);
      else            checkOutput($sformatf("rr%0d_ardata", g), bus.A_RDATA, 32'hA0 + g);
      tick();
      checkOutput($sformatf("rr%0d_idle", g),  {31'b0, bus.M_REQ}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.M_RDY = 1'b0;
    tick();

    $display("[TB] watchdog timeout");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    mreq_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!bus.M_REQ) break;
      mreq_cycles++;
    end
    checkOutput("to_mreq_len", mreq_cycles,        32'd15);
    checkOutput("to_tout",     {31'b0, bus.TOUT},  32'd1);
    checkOutput("to_cdata",    bus.C_DATAI,        32'hFFFFFFFF);
    checkOutput("to_hlt",      {31'b0, bus.C_HLT}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("to_hlt_idle", {31'b0, bus.C_HLT}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h600, 32'h55AA55AA, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("to_wr_mwr", {31'b0, bus.M_WR}, 32'd1);
    bus.M_RDY   = 1'b1;
    bus.M_RDATA = 32'h0BADBEEF;
    tick();
    checkOutput("to_wr_hlt",   {31'b0, bus.C_HLT}, 32'd0);
    checkOutput("to_sticky",   {31'b0, bus.TOUT},  32'd1);
    checkOutput("to_wr_cdata", bus.C_DATAI,        32'hFFFFFFFF);
    bus.M_RDY = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("[TB] reset during aux transfer");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h700, 32'h0);
    tick();
    checkOutput("rb_busy_mreq", {31'b0, bus.M_REQ}, 32'd1);
    res = 1'b0;
    tick();
    checkOutput("rb_mreq",  {31'b0, bus.M_REQ}, 32'd0);
    checkOutput("rb_ack",   {31'b0, bus.A_ACK}, 32'd0);
    checkOutput("rb_tout",  {31'b0, bus.TOUT},  32'd0);
    checkOutput("rb_maddr", bus.M_ADDR,         32'h0);
    res = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("rb_noack", {31'b0, bus.A_ACK}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h800, 32'h0, 1'b1, 1'b0, 32'h900, 32'h0);
    tick();
    checkOutput("rb_tie_addr", bus.M_ADDR,         32'h800);
    checkOutput("rb_tie_mreq", {31'b0, bus.M_REQ}, 32'd1);
    bus.M_RDY   = 1'b1;
    bus.M_RDATA = 32'h13579BDF;
    tick();
    checkOutput("rb_tie_cdata", bus.C_DATAI, 32'h13579BDF);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.M_RDY = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
